// File: rtl/pc_sequencer_if.sv
// Instruction-fetch handshake between pc_sequencer (master) and instruction memory (slave).
interface pc_sequencer_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter, fetch FSM and one-entry pending-redirect buffer for the multi-cycle MIPS core.
// Control transfers reported by decode take effect after the architectural delay slot.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  stall_i,
  input  logic                  br_valid_i,
  input  logic [2:0]            br_i,
  input  logic                  br_taken_i,
  input  logic [15:0]           imm16_i,
  input  logic [25:0]           imm26_i,
  input  logic [31:0]           rd1_i,
  pc_sequencer_if.master        imem,
  output logic [31:0]           instr_f_o,
  output logic [31:0]           pc_f_o,
  output logic                  instr_valid_o,
  output logic [31:0]           pc_d_o,
  output logic [31:0]           link_addr_o,
  output logic                  addr_err_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            imem_req_q, imem_req_d;
  logic [XLEN-1:0] imem_addr_q, imem_addr_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] instr_f_q, instr_f_d;
  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic            instr_valid_q, instr_valid_d;
  logic [XLEN-1:0] pc_d_q, pc_d_d;
  logic [XLEN-1:0] link_addr_q, link_addr_d;
  logic            pending_vld_q, pending_vld_d;
  logic [XLEN-1:0] pending_tgt_q, pending_tgt_d;
  logic            addr_err_q, addr_err_d;

  logic            consume;
  logic            br_redir;
  logic [XLEN-1:0] br_off;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] next_pc;

  // Redirect target relative to the branch's own PC (pc_d)
  always_comb begin : redirect_target
    br_off   = {{14{imm16_i[15]}}, imm16_i, 2'b00};
    br_redir = 1'b0;
    br_tgt   = pc_d_q + XLEN'(4) + br_off;
    case (br_i)
      3'b001: begin
        br_redir = br_taken_i;
      end
      3'b010, 3'b011: begin
        br_redir = 1'b1;
        br_tgt   = {pc_d_q[31:28], imm26_i, 2'b00};
      end
      3'b100, 3'b101: begin
        br_redir = 1'b1;
        br_tgt   = {rd1_i[31:2], 2'b00};
      end
      default: begin
        br_redir = 1'b0;
      end
    endcase
    br_redir = br_redir & br_valid_i;
  end

  // Next-state and datapath updates
  always_comb begin : next_state
    state_d       = state_q;
    imem_req_d    = imem_req_q;
    imem_addr_d   = imem_addr_q;
    fetch_pc_d    = fetch_pc_q;
    instr_f_d     = instr_f_q;
    pc_f_d        = pc_f_q;
    instr_valid_d = instr_valid_q;
    pc_d_d        = pc_d_q;
    link_addr_d   = link_addr_q;
    pending_vld_d = pending_vld_q;
    pending_tgt_d = pending_tgt_q;
    addr_err_d    = br_valid_i && (br_i[2:1] == 2'b10) && (rd1_i[1:0] != 2'b00);

    consume = (state_q == S_HOLD) && !stall_i;
    if (pending_vld_q) begin
      next_pc = pending_tgt_q;
    end else if (br_redir) begin
      next_pc = br_tgt;
    end else begin
      next_pc = pc_f_q + XLEN'(4);
    end

    case (state_q)
      S_IDLE: begin
        state_d     = S_FETCH;
        imem_req_d  = 1'b1;
        imem_addr_d = fetch_pc_q;
      end
      S_FETCH: begin
        if (imem.imem_ack) begin
          state_d       = S_HOLD;
          imem_req_d    = 1'b0;
          instr_f_d     = imem.imem_rdata;
          pc_f_d        = fetch_pc_q;
          instr_valid_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (consume) begin
          state_d       = S_FETCH;
          imem_req_d    = 1'b1;
          imem_addr_d   = next_pc;
          fetch_pc_d    = next_pc;
          instr_valid_d = 1'b0;
          pc_d_d        = pc_f_q;
          link_addr_d   = pc_f_q + XLEN'(8);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A delay-slot consume drains the buffer; otherwise the first redirect is held
    if (consume) begin
      pending_vld_d = 1'b0;
    end else if (br_redir && !pending_vld_q) begin
      pending_vld_d = 1'b1;
      pending_tgt_d = br_tgt;
    end
  end

  always_ff @(posedge clk_i) begin : state_reg
    if (reset_i) begin
      state_q       <= S_IDLE;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      fetch_pc_q    <= RESET_PC;
      instr_f_q     <= '0;
      pc_f_q        <= RESET_PC;
      instr_valid_q <= 1'b0;
      pc_d_q        <= RESET_PC;
      link_addr_q   <= RESET_PC + XLEN'(8);
      pending_vld_q <= 1'b0;
      pending_tgt_q <= '0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      fetch_pc_q    <= fetch_pc_d;
      instr_f_q     <= instr_f_d;
      pc_f_q        <= pc_f_d;
      instr_valid_q <= instr_valid_d;
      pc_d_q        <= pc_d_d;
      link_addr_q   <= link_addr_d;
      pending_vld_q <= pending_vld_d;
      pending_tgt_q <= pending_tgt_d;
      addr_err_q    <= addr_err_d;
    end
  end

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = imem_addr_q;
  assign instr_f_o      = instr_f_q;
  assign pc_f_o         = pc_f_q;
  assign instr_valid_o  = instr_valid_q;
  assign pc_d_o         = pc_d_q;
  assign link_addr_o    = link_addr_q;
  assign addr_err_o     = addr_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver/memory model push expectations, a monitor pops and compares.
module tb_pc_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, br_valid, br_taken;
  logic [2:0]  br;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] rd1;
  logic [31:0] instr_f, pc_f, pc_d, link_addr;
  logic        instr_valid, addr_err;

  pc_sequencer_if imem_bus ();

  pc_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .stall_i      (stall),
    .br_valid_i   (br_valid),
    .br_i         (br),
    .br_taken_i   (br_taken),
    .imm16_i      (imm16),
    .imm26_i      (imm26),
    .rd1_i        (rd1),
    .imem         (imem_bus),
    .instr_f_o    (instr_f),
    .pc_f_o       (pc_f),
    .instr_valid_o(instr_valid),
    .pc_d_o       (pc_d),
    .link_addr_o  (link_addr),
    .addr_err_o   (addr_err)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // scoreboard queues
  logic [31:0] q_fetch[$];
  logic [63:0] q_instr[$];
  logic [31:0] q_pcd[$];
  bit          q_err[$];

  // reference model state
  logic [31:0] m_fetch, m_pc_f, m_pc_d, m_pend_t;
  bit          m_pend_v;
  int          mem_cnt;
  bit          req_prev;
  int          mem_wait;
  bit          zw_check;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_msg(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic bit ref_target(input logic [31:0] pcd, input logic [2:0] b, input bit tk,
                                    input logic [15:0] i16, input logic [25:0] i26,
                                    input logic [31:0] r1, output logic [31:0] t);
    logic [31:0] off;
    off = 32'($signed(i16)) * 32'd4;
    t   = 32'h0;
    if (b == 3'b001) begin
      t = pcd + 32'd4 + off;
      return tk;
    end
    if (b == 3'b010 || b == 3'b011) begin
      t = {pcd[31:28], i26, 2'b00};
      return 1'b1;
    end
    if (b == 3'b100 || b == 3'b101) begin
      t = {r1[31:2], 2'b00};
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // one cycle of stimulus, applied at a negedge; updates the model and pushes expectations
  task automatic drive(input bit stl, input bit bv, input logic [2:0] b, input bit tk,
                       input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] r1);
    logic [31:0] t, nxt;
    bit rd, cons;
    stall = stl; br_valid = bv; br = b; br_taken = tk; imm16 = i16; imm26 = i26; rd1 = r1;
    cons = instr_valid && !stl;
    rd   = bv && ref_target(m_pc_d, b, tk, i16, i26, r1, t);
    q_err.push_back(bv && (b == 3'b100 || b == 3'b101) && (r1[1:0] != 2'b00));
    if (cons) begin
      nxt = m_pend_v ? m_pend_t : (rd ? t : m_pc_f + 32'd4);
      q_pcd.push_back(m_pc_f);
      m_pc_d   = m_pc_f;
      m_fetch  = nxt;
      q_fetch.push_back(nxt);
      m_pend_v = 1'b0;
    end else if (rd && !m_pend_v) begin
      m_pend_v = 1'b1;
      m_pend_t = t;
    end
    if (imem_bus.imem_req) begin
      if (!req_prev) mem_cnt = (mem_wait < 0) ? int'($urandom_range(0, 3)) : mem_wait;
      if (mem_cnt == 0) begin
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = $urandom;
        q_instr.push_back({m_fetch, imem_bus.imem_rdata});
        m_pc_f = m_fetch;
      end else begin
        imem_bus.imem_ack = 1'b0;
        mem_cnt--;
      end
    end else begin
      imem_bus.imem_ack   = ($urandom_range(0, 7) == 0);
      imem_bus.imem_rdata = $urandom;
    end
    req_prev = imem_bus.imem_req;
  endtask

  task automatic tick_plain();
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 1'b0, 16'h0, 26'h0, 32'h0);
  endtask

  task automatic do_reset(input bit stray_ack);
    @(negedge clk);
    reset = 1'b1; stall = 1'b0; br_valid = 1'b0;
    imem_bus.imem_ack = 1'b0;
    q_fetch.delete(); q_instr.delete(); q_pcd.delete(); q_err.delete();
    m_fetch = RESET_PC; m_pc_f = RESET_PC; m_pc_d = RESET_PC;
    m_pend_v = 1'b0; m_pend_t = 32'h0; mem_cnt = 0;
    q_fetch.push_back(RESET_PC);
    @(negedge clk);
    reset = 1'b0;
    imem_bus.imem_ack   = stray_ack;
    imem_bus.imem_rdata = $urandom;
    q_err.push_back(1'b0);
    req_prev = imem_bus.imem_req;
  endtask

  // advance until the DUT requests address a; returns at a negedge not yet driven
  task automatic seek_req(input logic [31:0] a);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (imem_bus.imem_req && imem_bus.imem_addr == a) found = 1'b1;
      else drive(1'b0, 1'b0, 3'b000, 1'b0, 16'h0, 26'h0, 32'h0);
    end
    if (!found) begin
      fail_msg("seek_req timeout");
      @(negedge clk);
    end
  endtask

  task automatic seek_hold(input logic [31:0] a);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (instr_valid && pc_f == a) found = 1'b1;
      else drive(1'b0, 1'b0, 3'b000, 1'b0, 16'h0, 26'h0, 32'h0);
    end
    if (!found) begin
      fail_msg("seek_hold timeout");
      @(negedge clk);
    end
  endtask

  // monitor: samples 1 time unit after each rising edge
  initial begin : monitor
    bit          p_req, p_val;
    logic [31:0] cur_addr;
    logic [63:0] cur_i;
    logic [31:0] e;
    int          cyc, last_rise;
    p_req = 1'b0; p_val = 1'b0; cyc = 0; last_rise = -1;
    cur_addr = '0; cur_i = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        chk("rst imem_req", 32'(imem_bus.imem_req), 32'd0);
        chk("rst imem_addr", imem_bus.imem_addr, RESET_PC);
        chk("rst instr_valid", 32'(instr_valid), 32'd0);
        chk("rst instr_f", instr_f, 32'd0);
        chk("rst pc_f", pc_f, RESET_PC);
        chk("rst pc_d", pc_d, RESET_PC);
        chk("rst link_addr", link_addr, RESET_PC + 32'd8);
        chk("rst addr_err", 32'(addr_err), 32'd0);
        p_req = 1'b0; p_val = 1'b0; last_rise = -1;
        continue;
      end
      if (q_err.size() == 0) fail_msg("addr_err queue underflow");
      else chk("addr_err", 32'(addr_err), 32'(q_err.pop_front()));
      chk("req_in_hold", 32'(imem_bus.imem_req & instr_valid), 32'd0);
      if (imem_bus.imem_req && !p_req) begin
        if (q_fetch.size() == 0) begin
          fail_msg("unexpected fetch request");
          cur_addr = imem_bus.imem_addr;
        end else begin
          cur_addr = q_fetch.pop_front();
          chk("fetch_addr", imem_bus.imem_addr, cur_addr);
        end
        if (zw_check && last_rise >= 0) chk("req_interval", 32'(cyc - last_rise), 32'd2);
        last_rise = cyc;
      end else if (imem_bus.imem_req) begin
        chk("addr_hold", imem_bus.imem_addr, cur_addr);
      end
      if (instr_valid && !p_val) begin
        if (q_instr.size() == 0) begin
          fail_msg("unexpected instr_valid");
          cur_i = {pc_f, instr_f};
        end else begin
          cur_i = q_instr.pop_front();
          chk("pc_f", pc_f, cur_i[63:32]);
          chk("instr_f", instr_f, cur_i[31:0]);
        end
      end else if (instr_valid) begin
        chk("pc_f hold", pc_f, cur_i[63:32]);
        chk("instr_f hold", instr_f, cur_i[31:0]);
      end
      if (!instr_valid && p_val) begin
        if (q_pcd.size() == 0) begin
          fail_msg("unexpected consume");
        end else begin
          e = q_pcd.pop_front();
          chk("pc_d", pc_d, e);
          chk("link_addr", link_addr, e + 32'd8);
        end
      end
      p_req = imem_bus.imem_req;
      p_val = instr_valid;
    end
  end

  initial begin : stimulus
    reset = 1'b1; stall = 1'b0; br_valid = 1'b0; br = 3'b000; br_taken = 1'b0;
    imm16 = '0; imm26 = '0; rd1 = '0;
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = '0;
    mem_wait = 0; zw_check = 1'b0; req_prev = 1'b0;

    // sequential fetch, zero-wait memory
    do_reset(1'b0);
    zw_check = 1'b1;
    repeat (12) tick_plain();
    zw_check = 1'b0;

    // taken branch at 0x3004 while delay slot 0x3008 is fetched, forward and backward
    do_reset(1'b0);
    seek_req(32'h3008);
    drive(1'b0, 1'b1, 3'b001, 1'b1, 16'h0003, 26'h0, 32'h0);
    repeat (10) tick_plain();
    do_reset(1'b0);
    seek_req(32'h3008);
    drive(1'b0, 1'b1, 3'b001, 1'b1, 16'hFFFF, 26'h0, 32'h0);
    repeat (10) tick_plain();

    // j and jal reported with the delay-slot consume
    for (int k = 0; k < 2; k++) begin
      do_reset(1'b0);
      seek_hold(32'h3004);
      drive(1'b0, 1'b1, (k == 0) ? 3'b010 : 3'b011, 1'b0, 16'h0, 26'h0000C10, 32'h0);
      repeat (10) tick_plain();
    end

    // misaligned jr
    do_reset(1'b0);
    seek_hold(32'h3004);
    drive(1'b0, 1'b1, 3'b100, 1'b0, 16'h0, 26'h0, 32'h0000_3023);
    repeat (10) tick_plain();

    // long stall in HOLD followed by a slow fetch
    do_reset(1'b0);
    seek_hold(32'h3004);
    mem_wait = 3;
    drive(1'b1, 1'b0, 3'b000, 1'b0, 16'h0, 26'h0, 32'h0);
    repeat (4) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 3'b000, 1'b0, 16'h0, 26'h0, 32'h0);
    end
    repeat (14) tick_plain();

    // reset in the middle of a fetch, with a late ack after reset
    do_reset(1'b0);
    seek_req(RESET_PC);
    drive(1'b0, 1'b0, 3'b000, 1'b0, 16'h0, 26'h0, 32'h0);
    do_reset(1'b1);
    mem_wait = 0;
    repeat (8) tick_plain();

    // second redirect while one is pending is dropped
    do_reset(1'b0);
    mem_wait = 2;
    seek_req(32'h3004);
    drive(1'b0, 1'b1, 3'b010, 1'b0, 16'h0, 26'h0000C10, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b100, 1'b0, 16'h0, 26'h0, 32'h0000_5000);
    repeat (14) tick_plain();

    // randomized traffic
    mem_wait = -1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        @(negedge clk);
        drive($urandom_range(0, 9) < 3, $urandom_range(0, 4) == 0, 3'($urandom),
              1'($urandom), 16'($urandom), 26'($urandom), $urandom);
      end
    end
    repeat (3) tick_plain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
